pll_clkena_gen: RTL and testbench

- Parametrised, runtime-reconfigurable successor to the single-output fixed-ratio PLL wrapper.
- Generates NUM_CH clock-enable streams from inclk0. Each stream has a programmable rational rate MUL/DIV (MUL ≤ DIV) and a programmable initial phase.
- Provides a locked flag with a lock-count window and a valid/ready reconfiguration port.
- Sits beside the PLL wrapper. Downstream logic stays on a single clock and uses clkena[k] instead of derived clocks.

---
 rtl/pll_clkena_gen.sv | 155 +++++++++++++++
 tb/tb_pll_clkena_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_clkena_gen.sv
// pll_clkena_gen: NUM_CH rational-rate clock-enable generators on a single clock.
// Each channel emits clkena pulses at density mul/div using a phase-accumulator.
// A valid reconfiguration restarts all channels together after a lock window,
// so every channel re-aligns to its programmed phase.
module pll_clkena_gen #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 16
) (
    input  logic              inclk0,
    input  logic              areset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_mul,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clkena,
    output logic              locked
);

    // Lock counter only needs to reach LOCK_COUNT-1.
    localparam int                LOCK_W    = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_COUNT - 1);

    typedef enum logic {
        ST_LOCKING = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    state_t            state_reg;
    logic [LOCK_W-1:0] lock_cnt_reg;
    logic              locked_reg;
    logic              ready_reg;
    logic              err_reg;

    logic              xfer;
    logic              ch_ok;
    logic              cfg_ok;
    logic              cfg_apply;
    logic              cfg_reject;
    logic              run_active;

    // A transfer can only happen in RUN, where ready is high.
    assign run_active = (state_reg == ST_RUN);
    assign xfer       = cfg_valid & ready_reg & run_active;

    // The full 3-bit channel index takes part in the range check, so
    // out-of-range channels are rejected rather than aliased.
    assign ch_ok  = ({29'd0, cfg_ch} < 32'(NUM_CH));
    assign cfg_ok = ch_ok
                  && (cfg_div != '0)
                  && (cfg_mul != '0)
                  && (cfg_mul <= cfg_div)
                  && (cfg_phase < cfg_div);

    assign cfg_apply  = xfer & cfg_ok;
    assign cfg_reject = xfer & ~cfg_ok;

    // Lock/run FSM with registered status outputs.
    always_ff @(posedge inclk0) begin
        if (areset) begin
            state_reg    <= ST_LOCKING;
            lock_cnt_reg <= '0;
            locked_reg   <= 1'b0;
            ready_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_LOCKING: begin
                    err_reg <= 1'b0;
                    if (lock_cnt_reg == LOCK_LAST) begin
                        state_reg    <= ST_RUN;
                        lock_cnt_reg <= '0;
                        locked_reg   <= 1'b1;
                        ready_reg    <= 1'b1;
                    end else begin
                        lock_cnt_reg <= lock_cnt_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    // A rejected config only flags an error; RUN continues.
                    err_reg <= cfg_reject;
                    if (cfg_apply) begin
                        state_reg    <= ST_LOCKING;
                        lock_cnt_reg <= '0;
                        locked_reg   <= 1'b0;
                        ready_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= ST_LOCKING;
                    lock_cnt_reg <= '0;
                    locked_reg   <= 1'b0;
                    ready_reg    <= 1'b0;
                    err_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign locked    = locked_reg;
    assign cfg_ready = ready_reg;
    assign cfg_err   = err_reg;

    // Per-channel rate registers and phase accumulators.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] mul_reg;
        logic [CNT_W-1:0] div_reg;
        logic [CNT_W-1:0] phase_reg;
        logic [CNT_W:0]   acc_reg;
        logic             ena_reg;
        logic [CNT_W:0]   sum_next;
        logic             hit;
        logic             sel;

        // One extra accumulator bit: acc < div and mul <= div, so the sum
        // never exceeds 2*div-1 and cannot wrap.
        assign sel      = cfg_apply && (cfg_ch == 3'(gi));
        assign sum_next = acc_reg + {1'b0, mul_reg};
        assign hit      = (sum_next >= {1'b0, div_reg});

        // Rate registers load on an accepted config; accumulator runs only in RUN
        // and is held at the phase otherwise so all channels restart aligned.
        always_ff @(posedge inclk0) begin
            if (areset) begin
                mul_reg   <= CNT_W'(1);
                div_reg   <= CNT_W'(1);
                phase_reg <= '0;
                acc_reg   <= '0;
                ena_reg   <= 1'b0;
            end else begin
                if (sel) begin
                    mul_reg   <= cfg_mul;
                    div_reg   <= cfg_div;
                    phase_reg <= cfg_phase;
                end
                if (!run_active || cfg_apply) begin
                    acc_reg <= {1'b0, phase_reg};
                    ena_reg <= 1'b0;
                end else if (hit) begin
                    acc_reg <= sum_next - {1'b0, div_reg};
                    ena_reg <= 1'b1;
                end else begin
                    acc_reg <= sum_next;
                    ena_reg <= 1'b0;
                end
            end
        end

        assign clkena[gi] = ena_reg;
    end

endmodule

// File: tb/tb_pll_clkena_gen.sv
// Bench for pll_clkena_gen: directed test-plan scenarios with literal expectations,
// then randomized configs and resets, all checked every cycle against a
// closed-form model (lock window from a start cycle, pulses from floor arithmetic).
module tb_pll_clkena_gen;

    localparam int NUM_CH     = 4;
    localparam int CNT_W      = 8;
    localparam int LOCK_COUNT = 16;

    logic              inclk0 = 1'b0;
    logic              areset = 1'b1;
    logic              cfg_valid = 1'b0;
    logic [2:0]        cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_mul = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic [CNT_W-1:0]  cfg_phase = '0;
    logic              cfg_ready;
    logic              cfg_err;
    logic [NUM_CH-1:0] clkena;
    logic              locked;

    pll_clkena_gen #(
        .NUM_CH(NUM_CH),
        .CNT_W(CNT_W),
        .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .inclk0(inclk0),
        .areset(areset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_mul(cfg_mul),
        .cfg_div(cfg_div),
        .cfg_phase(cfg_phase),
        .cfg_err(cfg_err),
        .clkena(clkena),
        .locked(locked)
    );

    always #5 inclk0 = ~inclk0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit model_on = 1'b0;
    int lock_start = 0;
    int err_cycle = -1;
    int m_mul[NUM_CH];
    int m_div[NUM_CH];
    int m_phase[NUM_CH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Locked once LOCK_COUNT cycles have elapsed since the lock window began.
    function automatic bit exp_locked(input int c);
        return (c - lock_start) >= LOCK_COUNT;
    endfunction

    // The n-th cycle after locked rises carries a pulse exactly when
    // floor((phase + n*mul)/div) steps up.
    function automatic bit exp_ena(input int k, input int c);
        longint n;
        longint a;
        longint b;
        n = longint'(c) - longint'(lock_start + LOCK_COUNT);
        if (n < 1) return 1'b0;
        a = (longint'(m_phase[k]) + n * longint'(m_mul[k])) / longint'(m_div[k]);
        b = (longint'(m_phase[k]) + (n - 1) * longint'(m_mul[k])) / longint'(m_div[k]);
        return a != b;
    endfunction

    // Model update on each edge, using the inputs present during cycle cyc.
    always @(posedge inclk0) begin
        bit ok;
        if (areset) begin
            model_on = 1'b1;
            lock_start = cyc + 1;
            err_cycle = -1;
            for (int k = 0; k < NUM_CH; k++) begin
                m_mul[k] = 1;
                m_div[k] = 1;
                m_phase[k] = 0;
            end
        end else if (model_on && cfg_valid && exp_locked(cyc)) begin
            ok = (int'(cfg_ch) < NUM_CH) && (cfg_div != 0) && (cfg_mul != 0)
               && (cfg_mul <= cfg_div) && (cfg_phase < cfg_div);
            $display("xfer cyc=%0d ch=%0d mul=%0d div=%0d phase=%0d %s",
                     cyc, cfg_ch, cfg_mul, cfg_div, cfg_phase, ok ? "accepted" : "rejected");
            if (ok) begin
                m_mul[cfg_ch] = int'(cfg_mul);
                m_div[cfg_ch] = int'(cfg_div);
                m_phase[cfg_ch] = int'(cfg_phase);
                lock_start = cyc + 1;
            end else begin
                err_cycle = cyc + 1;
            end
        end
        cyc = cyc + 1;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge inclk0) begin
        logic [NUM_CH-1:0] ev;
        if (model_on) begin
            for (int k = 0; k < NUM_CH; k++) ev[k] = exp_ena(k, cyc);
            chk("locked", 64'(locked), 64'(exp_locked(cyc)));
            chk("cfg_ready", 64'(cfg_ready), 64'(exp_locked(cyc)));
            chk("cfg_err", 64'(cfg_err), 64'(cyc == err_cycle));
            chk("clkena", 64'(clkena), 64'(ev));
        end
    end

    task automatic tick();
        @(posedge inclk0);
        #1;
    endtask

    // Advance to the middle (falling edge) of cycle c.
    task automatic goto(input int c);
        while (cyc < c) tick();
        @(negedge inclk0);
    endtask

    task automatic set_cfg(input int ch, input int mul, input int dv, input int ph);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_mul   = CNT_W'(mul);
        cfg_div   = CNT_W'(dv);
        cfg_phase = CNT_W'(ph);
    endtask

    int r0, t0, u0, l0, v0, r2, w0, r3, win;
    int inv_ch[4]  = '{0, 0, 5, 0};
    int inv_mul[4] = '{5, 1, 1, 1};
    int inv_div[4] = '{4, 0, 1, 4};
    int inv_ph[4]  = '{0, 0, 0, 4};
    logic [7:0] pat2;

    initial begin
        // Reset and lock window.
        areset = 1'b1;
        repeat (3) tick();
        areset = 1'b0;
        r0 = cyc;
        goto(r0 + 15);
        chk("lit_reset_locked15", 64'(locked), 64'd0);
        goto(r0 + 16);
        chk("lit_reset_locked16", 64'(locked), 64'd1);
        chk("lit_reset_ready16", 64'(cfg_ready), 64'd1);
        chk("lit_reset_ena16", 64'(clkena), 64'd0);
        goto(r0 + 17);
        chk("lit_reset_ena17", 64'(clkena), 64'hF);

        // Channel 1 at 1/4, phase 0.
        t0 = r0 + 30;
        goto(t0);
        set_cfg(1, 1, 4, 0);
        goto(t0 + 1);
        cfg_valid = 1'b0;
        chk("lit_ch1_unlock", 64'(locked), 64'd0);
        goto(t0 + 16);
        chk("lit_ch1_locked16", 64'(locked), 64'd0);
        goto(t0 + 17);
        chk("lit_ch1_locked17", 64'(locked), 64'd1);
        goto(t0 + 18);
        chk("lit_ch1_ena18", 64'(clkena), 64'b1101);
        goto(t0 + 20);
        chk("lit_ch1_ena20", 64'(clkena[1]), 64'd0);
        goto(t0 + 21);
        chk("lit_ch1_ena21", 64'(clkena[1]), 64'd1);
        goto(t0 + 25);
        chk("lit_ch1_ena25", 64'(clkena[1]), 64'd1);

        // Channel 2 at 3/8, phase 7: pulses at 1, 3, 6 after locked rises.
        u0 = t0 + 30;
        goto(u0);
        set_cfg(2, 3, 8, 7);
        goto(u0 + 1);
        cfg_valid = 1'b0;
        l0 = u0 + 17;
        pat2 = 8'b0010_0101;
        for (int n = 1; n <= 8; n++) begin
            goto(l0 + n);
            chk("lit_ch2_pattern", 64'(clkena[2]), 64'(pat2[n-1]));
        end
        win = 0;
        for (int n = 9; n <= 16; n++) begin
            goto(l0 + n);
            win += int'(clkena[2]);
        end
        chk("lit_ch2_window", 64'(win), 64'd3);

        // Rejected configs: one-cycle error, no relock.
        v0 = l0 + 20;
        for (int i = 0; i < 4; i++) begin
            goto(v0 + 4 * i);
            set_cfg(inv_ch[i], inv_mul[i], inv_div[i], inv_ph[i]);
            goto(v0 + 4 * i + 1);
            cfg_valid = 1'b0;
            chk("lit_inv_err", 64'(cfg_err), 64'd1);
            chk("lit_inv_locked", 64'(locked), 64'd1);
            goto(v0 + 4 * i + 2);
            chk("lit_inv_err_clear", 64'(cfg_err), 64'd0);
        end

        // Request held through LOCKING transfers on the first ready edge.
        goto(v0 + 20);
        areset = 1'b1;
        goto(v0 + 21);
        areset = 1'b0;
        r2 = v0 + 21;
        goto(r2 + 3);
        set_cfg(3, 1, 2, 1);
        goto(r2 + 15);
        chk("lit_hold_ready15", 64'(cfg_ready), 64'd0);
        goto(r2 + 16);
        chk("lit_hold_ready16", 64'(cfg_ready), 64'd1);
        goto(r2 + 17);
        cfg_valid = 1'b0;
        chk("lit_hold_relock17", 64'(locked), 64'd0);
        goto(r2 + 33);
        chk("lit_hold_locked33", 64'(locked), 64'd1);

        // Reset in the middle of a relock reverts all configs.
        w0 = r2 + 40;
        goto(w0);
        set_cfg(1, 1, 3, 2);
        goto(w0 + 1);
        cfg_valid = 1'b0;
        goto(w0 + 9);
        areset = 1'b1;
        goto(w0 + 10);
        areset = 1'b0;
        r3 = w0 + 10;
        goto(r3 + 15);
        chk("lit_abort_locked15", 64'(locked), 64'd0);
        goto(r3 + 16);
        chk("lit_abort_locked16", 64'(locked), 64'd1);
        goto(r3 + 17);
        chk("lit_abort_ena17", 64'(clkena), 64'hF);
        goto(r3 + 21);
        chk("lit_abort_ena21", 64'(clkena), 64'hF);

        // Randomized configs and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int dv;
            tick();
            areset    = ($urandom_range(0, 299) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 3'($urandom_range(0, 7));
            dv        = ($urandom_range(0, 3) == 0) ? int'($urandom_range(200, 255))
                                                    : int'($urandom_range(0, 12));
            cfg_div   = CNT_W'(dv);
            cfg_mul   = CNT_W'($urandom_range(0, (dv < 255) ? dv + 1 : 255));
            cfg_phase = CNT_W'($urandom_range(0, dv));
        end
        tick();
        areset = 1'b0;
        cfg_valid = 1'b0;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
